// File: rtl/rx_axi_wr_arb.sv
`default_nettype none
// rx_axi_wr_arb: round-robin scheduler sharing one AXI4 write master between two requesters at
// whole-burst granularity, with per-requester completed-burst counters and a sticky length check.
module rx_axi_wr_arb #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [LEN_W-1:0]    s0_awlen,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic                s0_wlast,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic [1:0]          s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,

  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [LEN_W-1:0]    s1_awlen,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic                s1_wlast,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic [1:0]          s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [LEN_W-1:0]    m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,

  output logic                grant_id,
  output logic                arb_busy,
  output logic [31:0]         burst_cnt0,
  output logic [31:0]         burst_cnt1,
  output logic                err_len,
  input  logic                err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W:0]     beat_cnt;

  logic in_addr;
  logic in_data;
  logic in_resp;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign in_resp = (state == RESP);

  assign m_axi_awsize  = 3'($clog2(DATA_W/8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;

  // Every channel is steered by the registered grant and gated by phase, so nothing leaks outside its phase.
  assign m_axi_awaddr  = in_addr ? (grant_id ? s1_awaddr : s0_awaddr) : '0;
  assign m_axi_awlen   = in_addr ? (grant_id ? s1_awlen  : s0_awlen)  : '0;
  assign m_axi_awvalid = in_addr & (grant_id ? s1_awvalid : s0_awvalid);
  assign s0_awready    = in_addr & ~grant_id & m_axi_awready;
  assign s1_awready    = in_addr &  grant_id & m_axi_awready;

  assign m_axi_wdata   = in_data ? (grant_id ? s1_wdata : s0_wdata) : '0;
  assign m_axi_wlast   = in_data & (grant_id ? s1_wlast  : s0_wlast);
  assign m_axi_wvalid  = in_data & (grant_id ? s1_wvalid : s0_wvalid);
  assign s0_wready     = in_data & ~grant_id & m_axi_wready;
  assign s1_wready     = in_data &  grant_id & m_axi_wready;

  assign s0_bvalid     = in_resp & ~grant_id & m_axi_bvalid;
  assign s1_bvalid     = in_resp &  grant_id & m_axi_bvalid;
  assign s0_bresp      = (in_resp & ~grant_id) ? m_axi_bresp : 2'b00;
  assign s1_bresp      = (in_resp &  grant_id) ? m_axi_bresp : 2'b00;
  assign m_axi_bready  = in_resp & (grant_id ? s1_bready : s0_bready);

  assign aw_hs    = m_axi_awvalid & m_axi_awready;
  assign w_hs     = m_axi_wvalid & m_axi_wready;
  assign b_hs     = in_resp & m_axi_bvalid & m_axi_bready;
  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      len_q      <= '0;
      beat_cnt   <= '0;
      burst_cnt0 <= 32'd0;
      burst_cnt1 <= 32'd0;
      err_len    <= 1'b0;
    end else begin
      // A length error detected below overrides a clear in the same cycle.
      if (err_clr) begin
        err_len <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (s0_awvalid | s1_awvalid) begin
            grant_id <= (s0_awvalid & s1_awvalid) ? ~last_grant : s1_awvalid;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len_q    <= m_axi_awlen;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_axi_wlast) begin
              if (beat_cnt != {1'b0, len_q}) begin
                err_len <= 1'b1;
              end
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            if (grant_id) begin
              burst_cnt1 <= burst_cnt1 + 32'd1;
            end else begin
              burst_cnt0 <= burst_cnt0 + 32'd1;
            end
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_axi_wr_arb.sv
`default_nettype none
// tb_rx_axi_wr_arb: table-driven vectors, hand sequences for reset/alternation, and randomized
// bursts checked against a burst-level arbitration model.
module tb_rx_axi_wr_arb;
  localparam int ADDR_W = 48;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] s0_awaddr, s1_awaddr;
  logic [LEN_W-1:0]  s0_awlen, s1_awlen;
  logic              s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [DATA_W-1:0] s0_wdata, s1_wdata;
  logic              s0_wlast, s0_wvalid, s0_wready, s1_wlast, s1_wvalid, s1_wready;
  logic [1:0]        s0_bresp, s1_bresp;
  logic              s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [LEN_W-1:0]  m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid, m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid, m_axi_bready;
  logic              grant_id, arb_busy, err_len, err_clr;
  logic [31:0]       burst_cnt0, burst_cnt1;

  // Requester-side state, one slot per requester
  logic [ADDR_W-1:0] q_addr [2];
  logic [LEN_W-1:0]  q_len  [2];
  int                q_nb   [2];
  int                q_tag  [2];
  logic              pend [2];
  logic              wv [2];
  logic              wl [2];
  logic              br [2];
  logic [DATA_W-1:0] wd [2];

  assign s0_awaddr = q_addr[0];  assign s1_awaddr = q_addr[1];
  assign s0_awlen  = q_len[0];   assign s1_awlen  = q_len[1];
  assign s0_awvalid = pend[0];   assign s1_awvalid = pend[1];
  assign s0_wdata  = wd[0];      assign s1_wdata  = wd[1];
  assign s0_wlast  = wl[0];      assign s1_wlast  = wl[1];
  assign s0_wvalid = wv[0];      assign s1_wvalid = wv[1];
  assign s0_bready = br[0];      assign s1_bready = br[1];

  rx_axi_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .grant_id(grant_id), .arb_busy(arb_busy), .burst_cnt0(burst_cnt0), .burst_cnt1(burst_cnt1),
    .err_len(err_len), .err_clr(err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tagc  = 0;
  // Burst-level reference model
  int mc0, mc1;
  bit mlast, merr;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] quiet();
    return {s0_awready, s0_wready, s0_bvalid, s1_awready, s1_wready, s1_bvalid,
            m_axi_awvalid, m_axi_wvalid, m_axi_bready};
  endfunction

  function automatic bit exp_grant(input logic p0, input logic p1, input bit last);
    if (p0 && p1) return !last;
    return p1;
  endfunction

  function automatic logic [DATA_W-1:0] beat(input int g, input int k);
    return {32'(q_tag[g]), 32'(g), 32'(k), 32'hC0DE_0000 ^ 32'(k)};
  endfunction

  task automatic model_reset();
    mc0 = 0; mc1 = 0; mlast = 1'b1; merr = 1'b0;
  endtask

  task automatic model_done(input bit g, input bit bad);
    if (g) mc1++; else mc0++;
    mlast = g;
    if (bad) merr = 1'b1;
  endtask

  task automatic setup(input int n, input int len, input int nb);
    tagc++;
    q_addr[n] = {16'(n + 1), 32'($urandom())};
    q_len[n]  = LEN_W'(len);
    q_nb[n]   = nb;
    q_tag[n]  = tagc;
    pend[n]   = 1'b1;
  endtask

  task automatic setup_rand(input int n);
    int len, nb, r;
    len = $urandom_range(0, 7);
    nb  = len + 1;
    r   = $urandom_range(0, 9);
    if (r == 0) nb = len + 2;
    else if (r == 1 && len > 0) nb = len;
    setup(n, len, nb);
  endtask

  // Serves one burst for the expected winner; called just after a falling edge with the FSM idle.
  task automatic run_one(input bit g, input int awd, input int wpct, input int bd, input logic [1:0] rsp,
                         input bit clr_first, input bit clr_last, input int abort_k);
    int c, k;
    bit hs;
    logic [1:0] ex;
    err_clr = clr_first;
    #1 chk("idle_quiet", {arb_busy, quiet()}, 0);
    @(negedge clk);
    err_clr = 1'b0;
    #1 chk("grant", {arb_busy, grant_id}, {1'b1, g});
    c = 0; hs = 1'b0;
    while (!hs) begin
      m_axi_awready = (c >= awd);
      #1;
      chk("aw_fwd", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, q_addr[g], q_len[g]});
      ex = '0; ex[g] = m_axi_awready;
      chk("aw_ready", {s1_awready, s0_awready}, ex);
      chk("aw_w_quiet", {m_axi_wvalid, m_axi_bready}, 0);
      hs = m_axi_awvalid && m_axi_awready;
      @(posedge clk); @(negedge clk);
      m_axi_awready = 1'b0;
      c++;
      if (!hs && c > awd + 20) begin chk("aw_timeout", 1, 0); return; end
    end
    pend[g] = 1'b0;
    k = 0; c = 0;
    while (k < q_nb[g]) begin
      wv[g] = ($urandom_range(0, 99) < 85);
      wd[g] = beat(g, k);
      wl[g] = (k == q_nb[g] - 1);
      m_axi_wready = ($urandom_range(0, 99) < wpct);
      err_clr = clr_last && wl[g];
      if (k == abort_k) begin
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("rst_quiet", quiet(), 0);
        chk("rst_state", {arb_busy, grant_id}, 0);
        chk("rst_cnt", {burst_cnt1, burst_cnt0}, 0);
        chk("rst_err", err_len, 0);
        rst_n = 1'b1;
        wv[g] = 1'b0; wl[g] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
        m_axi_wready = 1'b0; err_clr = 1'b0;
        model_reset();
        return;
      end
      #1;
      chk("w_valid", m_axi_wvalid, wv[g]);
      if (wv[g]) chk("w_beat", {m_axi_wlast, m_axi_wdata}, {wl[g], wd[g]});
      ex = '0; ex[g] = m_axi_wready;
      chk("w_ready", {s1_wready, s0_wready}, ex);
      chk("w_aw_quiet", m_axi_awvalid, 0);
      hs = wv[g] && m_axi_wready;
      @(posedge clk); @(negedge clk);
      if (hs) k++;
      c++;
      if (c > 64 * q_nb[g] + 200) begin chk("w_timeout", 1, 0); return; end
    end
    wv[g] = 1'b0; wl[g] = 1'b0; m_axi_wready = 1'b0; err_clr = 1'b0;
    c = 0; hs = 1'b0;
    while (!hs) begin
      m_axi_bvalid = (c >= bd);
      m_axi_bresp  = rsp;
      br[g] = ($urandom_range(0, 3) != 0);
      #1;
      ex = '0; ex[g] = m_axi_bvalid;
      chk("b_valid", {s1_bvalid, s0_bvalid}, ex);
      if (m_axi_bvalid) chk("b_resp", g ? s1_bresp : s0_bresp, rsp);
      chk("b_ready", m_axi_bready, br[g]);
      hs = m_axi_bvalid && br[g];
      @(posedge clk); @(negedge clk);
      c++;
      if (!hs && c > bd + 40) begin chk("b_timeout", 1, 0); return; end
    end
    m_axi_bvalid = 1'b0; br[g] = 1'b0;
    #1 chk("post_idle", {arb_busy, quiet()}, 0);
  endtask

  typedef struct {
    logic [1:0] req;
    int         len;
    int         nb;
    logic [1:0] rsp;
    int         awd;
    int         wpct;
    bit         clr;
    bit         clr_last;
    bit         eg;
    bit         eerr;
    int         ec0;
    int         ec1;
  } vec_t;

  vec_t vt [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    vt[0]  = '{2'b01, 15, 16, 2'd0,  0, 100, 0, 0, 0, 0, 1, 0};
    vt[1]  = '{2'b10,  7,  8, 2'd1,  2, 100, 0, 0, 1, 0, 1, 1};
    vt[2]  = '{2'b11,  3,  4, 2'd0,  1,  70, 0, 0, 0, 0, 2, 1};
    vt[3]  = '{2'b11,  3,  4, 2'd0,  0,  70, 0, 0, 1, 0, 2, 2};
    vt[4]  = '{2'b01,  3,  3, 2'd0,  0, 100, 0, 0, 0, 1, 3, 2};
    vt[5]  = '{2'b10,  0,  1, 2'd0,  0, 100, 0, 0, 1, 1, 3, 3};
    vt[6]  = '{2'b01,  3,  4, 2'd0,  0, 100, 1, 0, 0, 0, 4, 3};
    vt[7]  = '{2'b01,  0,  1, 2'd2,  0, 100, 0, 0, 0, 0, 5, 3};
    vt[8]  = '{2'b10,  2,  5, 2'd0, 20,  50, 0, 0, 1, 1, 5, 4};
    vt[9]  = '{2'b01,  1,  3, 2'd0,  0,  60, 1, 1, 0, 1, 6, 4};
    vt[10] = '{2'b11,  0,  1, 2'd3,  1, 100, 0, 0, 1, 1, 6, 5};
    vt[11] = '{2'b10,  1,  2, 2'd0,  0, 100, 1, 0, 1, 0, 6, 6};

    for (int n = 0; n < 2; n++) begin
      q_addr[n] = '0; q_len[n] = '0; q_nb[n] = 1; q_tag[n] = 0;
      pend[n] = 1'b0; wv[n] = 1'b0; wl[n] = 1'b0; br[n] = 1'b0; wd[n] = '0;
    end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_quiet", quiet(), 0);
    chk("reset_state", {arb_busy, grant_id}, 0);
    chk("reset_cnt", {burst_cnt1, burst_cnt0}, 0);
    chk("reset_err", err_len, 0);
    chk("awsize", m_axi_awsize, 3'd4);
    chk("awburst", m_axi_awburst, 2'b01);
    chk("wstrb", m_axi_wstrb, {(DATA_W/8){1'b1}});
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      for (int n = 0; n < 2; n++)
        if (vt[i].req[n]) setup(n, vt[i].len, vt[i].nb);
      run_one(vt[i].eg, vt[i].awd, vt[i].wpct, 1, vt[i].rsp, vt[i].clr, vt[i].clr_last, -1);
      model_done(vt[i].eg, vt[i].nb != vt[i].len + 1);
      pend[0] = 1'b0; pend[1] = 1'b0;
      chk("vec_cnt0", burst_cnt0, vt[i].ec0);
      chk("vec_cnt1", burst_cnt1, vt[i].ec1);
      chk("vec_err", err_len, vt[i].eerr);
    end

    // Reset in the middle of an s1 data phase, then a fresh s1 burst
    setup(1, 7, 8);
    run_one(1'b1, 0, 100, 1, 2'd0, 0, 0, 3);
    setup(1, 3, 4);
    run_one(1'b1, 1, 80, 1, 2'd0, 0, 0, -1);
    model_done(1'b1, 1'b0);
    chk("post_rst_cnt", {burst_cnt1, burst_cnt0}, {32'(mc1), 32'(mc0)});

    // Both requesters continuously pending: strict alternation starting with s0
    setup(0, 3, 4);
    setup(1, 3, 4);
    for (int i = 0; i < 8; i++) begin
      g = exp_grant(pend[0], pend[1], mlast);
      run_one(g, $urandom_range(0, 2), 80, 1, 2'd0, 0, 0, -1);
      model_done(g, 1'b0);
      setup(g, 3, 4);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    chk("alt_cnt0", burst_cnt0, mc0);
    chk("alt_cnt1", burst_cnt1, mc1);

    for (int i = 0; i < 40; i++) begin
      bit clr;
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 99) < 60) setup_rand(n);
      if (!pend[0] && !pend[1]) setup_rand($urandom_range(0, 1));
      g = exp_grant(pend[0], pend[1], mlast);
      clr = ($urandom_range(0, 4) == 0);
      if (clr) merr = 1'b0;
      run_one(g, $urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), clr, 0, -1);
      model_done(g, q_nb[g] != int'(q_len[g]) + 1);
      chk("rnd_cnt0", burst_cnt0, mc0);
      chk("rnd_cnt1", burst_cnt1, mc1);
      chk("rnd_err", err_len, merr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
